render_pixel_sequencer: RTL and testbench
=========================================

Name: render_pixel_sequencer

Overview:
Source end of the renderer pixel-write interface. Sweeps every render-resolution pixel (x, then y) once per frame and issues coordinate requests to a variable-latency shading pipeline under valid/ready. It pairs in-order shading responses with the coordinates held in an internal FIFO. It then drives the framebuffer writer's block coordinate, colour, visible and valid inputs.

Parameters:
WIDTH, 512, render-buffer width in pixels
HEIGHT, 384, render-buffer height in pixels
MAX_OUTSTANDING, 8, maximum issued-but-unanswered requests; coordinate FIFO depth (power of 2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
start_frame  input  1  one-cycle pulse; begins a frame sweep when idle
busy  output  1  high from accepted start until frame_done
frame_done  output  1  one-cycle pulse when last pixel is written out
frame_count  output  8  completed frames, wraps at 255->0
req_x  output  11  shader request x
req_y  output  10  shader request y
req_valid  output  1  request valid
req_ready  input  1  shader accepts request
resp_valid  input  1  shader response valid; responses arrive in request order, no backpressure
resp_r  input  4  red
resp_g  input  4  green
resp_b  input  4  blue
resp_visible  input  1  pixel hit a visible block
x_out_block  output  11  framebuffer write x
y_out_block  output  10  framebuffer write y
r_out_formatted  output  4  write red
g_out_formatted  output  4  write green
b_out_formatted  output  4  write blue
block_visible_out  output  1  write visible flag
valid_out  output  1  write strobe
protocol_error  output  1  sticky; response received with FIFO empty

Behaviour:
- Reset (asynchronous, active-high): state IDLE, cursor (0,0), FIFO empty, all outputs 0, frame_count 0, protocol_error 0.
- States: IDLE, ISSUE, DRAIN.
- IDLE -> ISSUE on start_frame:
  - cursor set to (0,0); busy high from the next cycle.
  - start_frame in ISSUE/DRAIN is ignored.
- Request valid: req_valid = (state==ISSUE) && (count < MAX_OUTSTANDING). It is combinational from registered state; req_x/req_y equal the cursor.
- Transfer = req_valid && req_ready. On transfer:
  - the cursor is pushed to the FIFO.
  - x increments; at x==WIDTH-1, x wraps to 0 and y increments.
- Transfer of (WIDTH-1, HEIGHT-1): cursor returns to (0,0); ISSUE -> DRAIN.
- Full FIFO: no push while count==MAX_OUTSTANDING, even if a pop happens in the same cycle. req_valid reasserts the cycle after count drops.
- Simultaneous push and pop: count unchanged; head and tail both advance.
- Response with FIFO non-empty: pop the head. Next cycle:
  - valid_out=1.
  - x/y_out_block = popped coordinate.
  - colour = resp_r/g/b; block_visible_out = resp_visible.
  - Latency is exactly 1 cycle.
- Invisible pixels forward resp colour unchanged. Zeroing is the writer's job.
- Response with FIFO empty: discarded, valid_out stays 0, protocol_error set until reset.
- valid_out is low in all other cycles. Data outputs hold their last value.
- DRAIN -> IDLE when the FIFO is empty and no response is pending that cycle.
  - frame_done pulses 1 cycle, coincident with the last valid_out.
  - frame_count increments and busy drops that same cycle.
- Responses may arrive in IDLE or DRAIN; they are handled identically.
- Width rules:
  - Coordinates compare against WIDTH-1 and HEIGHT-1 at full port width; no truncation.
  - count is $clog2(MAX_OUTSTANDING)+1 bits.
- Reset mid-frame: immediate return to reset values. Shader responses after reset deassertion with an empty FIFO raise protocol_error. The integrating system must reset the shader together with this block.

Decomposition:
- Shared package render_pkg:
  - RENDER_WIDTH, RENDER_HEIGHT constants (the framebuffer writer uses the same values).
  - Coordinate widths.
  - sequencer_state_t enum {IDLE, ISSUE, DRAIN}.
  - Packed pixel_coord_t {x[10:0], y[9:0]}.
- Sub-module coord_fifo: synchronous FIFO of pixel_coord_t, parameter DEPTH, with push/pop/full/empty/count and asynchronous reset.

Test Plan:
1. WIDTH=4, HEIGHT=2, req_ready=1, response 3 cycles after each request:
   - requests (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1) in order.
   - 8 valid_out with matching coordinates.
   - frame_done once, frame_count=1.
2. MAX_OUTSTANDING=2, responses withheld:
   - exactly 2 transfers, then req_valid=0.
   - one response -> req_valid=1 next cycle, third request is (2,0).
3. req_ready toggling 1/0 every cycle: each coordinate issued exactly once; no skip or duplicate across 2 frames; frame_count=2.
4. resp_valid with FIFO empty in IDLE: valid_out stays 0, protocol_error=1 and holds.
5. Reset asserted mid-ISSUE at cursor (2,0) with 2 outstanding:
   - outputs zero asynchronously, busy=0.
   - next start_frame restarts at (0,0).
6. start_frame pulsed during DRAIN: ignored; exactly one frame_done; IDLE afterwards.

Source files
------------

// File: rtl/render_pkg.sv
// render_pkg
//   Shared definitions for the renderer pixel path: render resolution (also
//   used by the framebuffer writer), coordinate widths, the sequencer state
//   encoding and the packed pixel coordinate carried through the FIFO.
package render_pkg;

   localparam int RENDER_WIDTH  = 512;
   localparam int RENDER_HEIGHT = 384;
   localparam int COORD_X_W     = 11;
   localparam int COORD_Y_W     = 10;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} sequencer_state_t;

   typedef struct packed {
      logic [COORD_X_W-1:0] x;
      logic [COORD_Y_W-1:0] y;
   } pixel_coord_t;

endpackage

// File: rtl/coord_fifo.sv
// coord_fifo
//   Synchronous FIFO of pixel coordinates with asynchronous active-high reset.
//   Ports:
//     clk_in, rst_in      clock, async active-high reset
//     push, push_data     write request / data (ignored when full)
//     pop                 read request (ignored when empty)
//     pop_data            head entry, valid whenever !empty
//     full, empty, count  occupancy status
import render_pkg::*;

module coord_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       push,
   input  pixel_coord_t               push_data,
   input  logic                       pop,
   output pixel_coord_t               pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   pixel_coord_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk_in) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/render_pixel_sequencer.sv
// render_pixel_sequencer
//   Sweeps every render pixel (x fastest, then y) once per frame, issuing
//   coordinate requests to a variable-latency shader under valid/ready. Issued
//   coordinates wait in a FIFO and are paired with in-order shader responses,
//   producing one framebuffer write the cycle after each response.
//   Ports:
//     clk_in, rst_in            clock, async active-high reset
//     start_frame               pulse; starts a sweep when idle
//     busy, frame_done          sweep in progress / last write strobe
//     frame_count               completed frames (wraps)
//     req_x/req_y/req_valid/req_ready        shader request channel
//     resp_valid/resp_r/g/b/resp_visible      shader response channel
//     x/y_out_block, r/g/b_out_formatted, block_visible_out, valid_out
//                               framebuffer write channel
//     protocol_error            sticky; response arrived with nothing pending
import render_pkg::*;

module render_pixel_sequencer #(
   parameter int WIDTH           = RENDER_WIDTH,
   parameter int HEIGHT          = RENDER_HEIGHT,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        start_frame,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  frame_count,
   output logic [10:0] req_x,
   output logic [9:0]  req_y,
   output logic        req_valid,
   input  logic        req_ready,
   input  logic        resp_valid,
   input  logic [3:0]  resp_r,
   input  logic [3:0]  resp_g,
   input  logic [3:0]  resp_b,
   input  logic        resp_visible,
   output logic [10:0] x_out_block,
   output logic [9:0]  y_out_block,
   output logic [3:0]  r_out_formatted,
   output logic [3:0]  g_out_formatted,
   output logic [3:0]  b_out_formatted,
   output logic        block_visible_out,
   output logic        valid_out,
   output logic        protocol_error
);

   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [COORD_X_W-1:0] X_LAST = COORD_X_W'(WIDTH - 1);
   localparam logic [COORD_Y_W-1:0] Y_LAST = COORD_Y_W'(HEIGHT - 1);

   sequencer_state_t state, state_nxt;
   pixel_coord_t     cursor;
   pixel_coord_t     head;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             last_pixel;
   logic             start_ok;
   logic             drain_done;

   assign req_x      = cursor.x;
   assign req_y      = cursor.y;
   assign push       = req_valid && req_ready;
   assign pop        = resp_valid && !empty;
   assign last_pixel = (cursor.x == X_LAST) && (cursor.y == Y_LAST);

   coord_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push      (push),
      .push_data (cursor),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nxt;
   end

   // The frame finishes on the edge that pops the last outstanding entry, so
   // frame_done, busy and frame_count all change together with the final
   // write strobe. The empty/no-response term keeps DRAIN from locking up.
   always_comb begin
      state_nxt  = state;
      req_valid  = 1'b0;
      start_ok   = 1'b0;
      drain_done = 1'b0;
      case (state)
         IDLE: begin
            if (start_frame) begin
               start_ok  = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            req_valid = !full;
            if (req_valid && req_ready && last_pixel) state_nxt = DRAIN;
         end
         DRAIN: begin
            drain_done = (pop && count == CW'(1)) || (empty && !resp_valid);
            if (drain_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cursor            <= '0;
         busy              <= 1'b0;
         frame_done        <= 1'b0;
         frame_count       <= '0;
         x_out_block       <= '0;
         y_out_block       <= '0;
         r_out_formatted   <= '0;
         g_out_formatted   <= '0;
         b_out_formatted   <= '0;
         block_visible_out <= 1'b0;
         valid_out         <= 1'b0;
         protocol_error    <= 1'b0;
      end else begin
         if (start_ok) begin
            cursor <= '0;
         end else if (push) begin
            if (last_pixel) begin
               cursor <= '0;
            end else if (cursor.x == X_LAST) begin
               cursor.x <= '0;
               cursor.y <= cursor.y + COORD_Y_W'(1);
            end else begin
               cursor.x <= cursor.x + COORD_X_W'(1);
            end
         end

         if (start_ok)        busy <= 1'b1;
         else if (drain_done) busy <= 1'b0;

         frame_done <= drain_done;
         if (drain_done) frame_count <= frame_count + 8'd1;

         // Colour is forwarded untouched even for invisible pixels.
         valid_out <= pop;
         if (pop) begin
            x_out_block       <= head.x;
            y_out_block       <= head.y;
            r_out_formatted   <= resp_r;
            g_out_formatted   <= resp_g;
            b_out_formatted   <= resp_b;
            block_visible_out <= resp_visible;
         end

         if (resp_valid && empty) protocol_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_render_pixel_sequencer.sv
module tb_render_pixel_sequencer;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        start_frame;
   logic        busy;
   logic        frame_done;
   logic [7:0]  frame_count;
   logic [10:0] req_x;
   logic [9:0]  req_y;
   logic        req_valid;
   logic        req_ready;
   logic        resp_valid;
   logic [3:0]  resp_r, resp_g, resp_b;
   logic        resp_visible;
   logic [10:0] x_out_block;
   logic [9:0]  y_out_block;
   logic [3:0]  r_out_formatted, g_out_formatted, b_out_formatted;
   logic        block_visible_out;
   logic        valid_out;
   logic        protocol_error;

   render_pixel_sequencer #(.WIDTH(4), .HEIGHT(2), .MAX_OUTSTANDING(2)) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .start_frame       (start_frame),
      .busy              (busy),
      .frame_done        (frame_done),
      .frame_count       (frame_count),
      .req_x             (req_x),
      .req_y             (req_y),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .resp_valid        (resp_valid),
      .resp_r            (resp_r),
      .resp_g            (resp_g),
      .resp_b            (resp_b),
      .resp_visible      (resp_visible),
      .x_out_block       (x_out_block),
      .y_out_block       (y_out_block),
      .r_out_formatted   (r_out_formatted),
      .g_out_formatted   (g_out_formatted),
      .b_out_formatted   (b_out_formatted),
      .block_visible_out (block_visible_out),
      .valid_out         (valid_out),
      .protocol_error    (protocol_error)
   );

   always #5 clk_in = ~clk_in;

   typedef struct { int due; int x; int y; } pend_t;
   typedef struct { int cyc; int x; int y; int r; int g; int b; int vis; } exp_t;

   pend_t pend[$];   // requests the shader model still owes a response for
   exp_t  sb[$];     // expected framebuffer writes, in order

   int cyc      = 0;
   int req_k    = 0;
   int tot_xfer = 0;
   int fd_cnt   = 0;
   int rn       = 0;
   int n_vec    = 0;
   int n_miss   = 0;
   int credit   = 0;
   bit auto_resp  = 1'b0;
   bit rdy_toggle = 1'b0;
   bit stray      = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, want);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk_in); #1 start_frame = 1'b1;
      @(posedge clk_in); #1 start_frame = 1'b0;
   endtask

   task automatic wait_frame(input int target);
      int n = 0;
      while (fd_cnt < target && n < 300) begin
         @(posedge clk_in);
         n++;
      end
      check("frame_done_seen", fd_cnt, target);
   endtask

   // Shader model: ready pattern plus in-order responses 3 cycles after each
   // request (or one at a time on credit when auto_resp is off).
   initial begin
      pend_t p;
      forever begin
         @(posedge clk_in);
         cyc++;
         #1;
         resp_valid = 1'b0;
         req_ready  = rdy_toggle ? cyc[0] : 1'b1;
         if (stray) begin
            resp_valid = 1'b1;
            resp_r = 4'hF; resp_g = 4'hF; resp_b = 4'hF; resp_visible = 1'b1;
            stray = 1'b0;
         end else if (pend.size() > 0 && (auto_resp ? pend[0].due <= cyc : credit > 0)) begin
            p = pend.pop_front();
            if (!auto_resp) credit--;
            resp_valid   = 1'b1;
            resp_r       = 4'(rn);
            resp_g       = 4'(rn) ^ 4'hA;
            resp_b       = 4'(rn + 5);
            resp_visible = rn[0];
            sb.push_back('{cyc + 1, p.x, p.y, rn & 15, (rn & 15) ^ 10, (rn + 5) & 15, rn & 1});
            rn++;
         end
      end
   end

   // Monitor: request order, write-channel scoreboard, frame_done alignment.
   always @(negedge clk_in) begin
      exp_t e;
      if (!rst_in) begin
         if (req_valid && req_ready) begin
            check("req_x", req_x, req_k % 4);
            check("req_y", req_y, (req_k / 4) % 2);
            pend.push_back('{cyc + 3, req_k % 4, (req_k / 4) % 2});
            req_k++;
            tot_xfer++;
         end
         if (valid_out) begin
            if (sb.size() == 0) begin
               check("unexpected_valid_out", 1, 0);
            end else begin
               e = sb.pop_front();
               check("out_latency", cyc, e.cyc);
               check("out_x", x_out_block, e.x);
               check("out_y", y_out_block, e.y);
               check("out_r", r_out_formatted, e.r);
               check("out_g", g_out_formatted, e.g);
               check("out_b", b_out_formatted, e.b);
               check("out_vis", block_visible_out, e.vis);
            end
         end
         if (frame_done) begin
            fd_cnt++;
            check("done_with_valid", valid_out, 1);
            check("busy_at_done", busy, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      int target;
      int fdb;
      rst_in = 1'b1; start_frame = 1'b0; req_ready = 1'b0; resp_valid = 1'b0;
      resp_r = '0; resp_g = '0; resp_b = '0; resp_visible = 1'b0;
      #23;
      check("rst_busy", busy, 0);
      check("rst_req_valid", req_valid, 0);
      check("rst_valid_out", valid_out, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_protocol_error", protocol_error, 0);
      check("rst_req_xy", {req_x, req_y}, 0);
      @(negedge clk_in) rst_in = 1'b0;

      // 1: full frame, ready always high, 3-cycle shader latency
      auto_resp = 1'b1;
      pulse_start();
      check("busy_after_start", busy, 1);
      wait_frame(1);
      check("t1_frame_count", frame_count, 1);
      check("t1_xfers", tot_xfer, 8);
      repeat (3) @(posedge clk_in);
      #2;
      check("t1_sb_empty", sb.size(), 0);
      check("t1_busy_idle", busy, 0);

      // 2: responses withheld, outstanding limit of 2
      auto_resp = 1'b0;
      pulse_start();
      repeat (6) @(posedge clk_in);
      #2;
      check("t2_xfers_at_limit", tot_xfer, 10);
      check("t2_req_valid_blocked", req_valid, 0);
      @(negedge clk_in) credit = 1;
      n = 0;
      while (credit > 0 && n < 10) begin
         @(posedge clk_in);
         n++;
      end
      #2;
      check("t2_req_valid_reassert", req_valid, 1);
      check("t2_third_req_x", req_x, 2);
      auto_resp = 1'b1;
      wait_frame(2);
      check("t2_frame_count", frame_count, 2);

      // 3: req_ready toggling, two frames back to back
      rdy_toggle = 1'b1;
      pulse_start();
      wait_frame(3);
      pulse_start();
      wait_frame(4);
      check("t3_frame_count", frame_count, 4);
      check("t3_xfers", tot_xfer, 32);
      rdy_toggle = 1'b0;

      // 4: response with nothing outstanding while idle
      repeat (3) @(posedge clk_in);
      #2;
      check("t4_perr_before", protocol_error, 0);
      @(negedge clk_in) stray = 1'b1;
      repeat (2) @(posedge clk_in);
      #2;
      check("t4_no_valid_out", valid_out, 0);
      check("t4_perr_set", protocol_error, 1);
      repeat (5) @(posedge clk_in);
      #2;
      check("t4_perr_sticky", protocol_error, 1);

      // 5: reset mid-ISSUE with cursor at (2,0) and two outstanding
      auto_resp = 1'b0;
      pulse_start();
      repeat (4) @(posedge clk_in);
      #2;
      check("t5_xfers", tot_xfer, 34);
      check("t5_cursor_x", req_x, 2);
      @(negedge clk_in);
      #2 rst_in = 1'b1;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_req_valid", req_valid, 0);
      check("t5_rst_req_x", req_x, 0);
      check("t5_rst_frame_count", frame_count, 0);
      check("t5_rst_perr", protocol_error, 0);
      check("t5_rst_out_x", x_out_block, 0);
      check("t5_rst_out_r", r_out_formatted, 0);
      pend.delete();
      sb.delete();
      req_k  = 0;
      credit = 0;
      @(posedge clk_in);
      #3 rst_in = 1'b0;
      auto_resp = 1'b1;
      fdb = fd_cnt;
      pulse_start();
      wait_frame(fdb + 1);
      check("t5_frame_count", frame_count, 1);

      // 6: start_frame pulsed while draining is ignored
      pulse_start();
      target = tot_xfer + 8;
      n = 0;
      while (tot_xfer < target && n < 300) begin
         @(posedge clk_in);
         n++;
      end
      #1 start_frame = 1'b1;
      @(posedge clk_in);
      #1 start_frame = 1'b0;
      fdb = fd_cnt;
      repeat (30) @(posedge clk_in);
      #2;
      check("t6_one_done", fd_cnt, fdb + 1);
      check("t6_no_restart", tot_xfer, target);
      check("t6_idle_busy", busy, 0);
      check("t6_idle_req_valid", req_valid, 0);
      check("t6_frame_count", frame_count, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
